// File: rtl/md_iter.sv
// Multiply/divide unit holding architectural HI/LO: fixed-latency multiply and MAC,
// restoring one-bit-per-cycle divider with a final sign-fixup step.
module md_iter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       MDOp,
  input  logic             Start,
  input  logic             IRQ,
  input  logic             eret,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntMax = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              fix_q, busy_q, done_q;
  logic              sgn_q, acc_q, sub_q;
  logic [WIDTH-1:0]  a_q, b_q, hi_q, lo_q, quo_q, rem_q, dvs_q;

  logic              issue, is_mul, is_div, is_mthi, is_mtlo, op_signed, op_acc, op_sub;
  logic [WIDTH-1:0]  a_mag, b_mag;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    op_signed = 1'b0;
    op_acc    = 1'b0;
    op_sub    = 1'b0;
    case (MDOp)
      4'd1:    begin is_mul = 1'b1; op_signed = 1'b1; end
      4'd2:    is_mul = 1'b1;
      4'd3:    begin is_div = 1'b1; op_signed = 1'b1; end
      4'd4:    is_div = 1'b1;
      4'd5:    begin is_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      4'd6:    begin is_mul = 1'b1; op_acc = 1'b1; end
      4'd7:    begin is_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      4'd8:    begin is_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      4'd9:    is_mthi = 1'b1;
      4'd10:   is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign issue = Start & ~IRQ & ~eret & ~busy_q;
  assign a_mag = (op_signed & A[WIDTH-1]) ? -A : A;
  assign b_mag = (op_signed & B[WIDTH-1]) ? -B : B;

  // Product is formed from the captured operands; accumulate uses HI/LO, frozen while busy.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
  assign a_ext   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = !acc_q ? prod : (sub_q ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod);

  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] quo_fix, rem_fix, div_hi, div_lo;
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign quo_fix = (sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
  assign rem_fix = (sgn_q & a_q[WIDTH-1]) ? -rem_q : rem_q;

  always_comb begin
    div_hi = rem_fix;
    div_lo = quo_fix;
    if (b_q == '0) begin
      div_hi = a_q;
      div_lo = '1;
    end else if (sgn_q && a_q == MinNeg && b_q == '1) begin
      div_hi = '0;
      div_lo = a_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fix_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sgn_q   <= 1'b0;
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (issue) begin
            if (is_mthi) begin
              hi_q <= A;
            end else if (is_mtlo) begin
              lo_q <= A;
            end else if (is_mul || is_div) begin
              busy_q <= 1'b1;
              a_q    <= A;
              b_q    <= B;
              sgn_q  <= op_signed;
              acc_q  <= op_acc;
              sub_q  <= op_sub;
              if (is_mul) begin
                state_q <= StMul;
                cnt_q   <= CntW'(MUL_LAT - 1);
              end else begin
                state_q <= StDiv;
                cnt_q   <= CntW'(WIDTH - 1);
                fix_q   <= 1'b0;
                quo_q   <= a_mag;
                rem_q   <= '0;
                dvs_q   <= b_mag;
              end
            end
          end
        end
        StMul: begin
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= mul_res;
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDiv: begin
          if (fix_q) begin
            hi_q    <= div_hi;
            lo_q    <= div_lo;
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_q <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            if (cnt_q == '0) fix_q <= 1'b1;
            else             cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_iter.sv
// Scoreboard bench for md_iter: expected HI/LO pushed at issue, compared on each Done pulse.
module tb_md_iter;

  localparam int unsigned W      = 32;
  localparam int unsigned Lat    = 5;
  localparam int          DivLat = W + 1;

  logic        clk = 1'b0, reset = 1'b0, Start = 1'b0, IRQ = 1'b0, eret = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_v;
  logic [31:0] m_hi = '0, m_lo = '0;

  md_iter #(.WIDTH(W), .MUL_LAT(Lat)) dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .Start(Start), .IRQ(IRQ), .eret(eret),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    logic signed [63:0] sa, sbv, ps;
    logic [63:0]        pu;
    logic signed [31:0] q, r;
    sa  = $signed(a);
    sbv = $signed(b);
    ps  = sa * sbv;
    pu  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      4'd5: return acc + ps;
      4'd6: return acc + pu;
      4'd7: return acc - ps;
      4'd8: return acc - pu;
      4'd9: return {a, acc[31:0]};
      4'd10: return {acc[63:32], a};
      default: return acc;
    endcase
  endfunction

  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(Done), 64'd0);
      end else begin
        exp_v = sb.pop_front();
        check("commit_hilo", {HI, LO}, exp_v);
      end
    end
  end

  // Called at a negedge; returns at the negedge where Done is seen.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit intrude);
    logic [63:0] e;
    int n;
    e = model(op, a, b, {m_hi, m_lo});
    sb.push_back(e);
    {m_hi, m_lo} = e;
    MDOp = op; A = a; B = b; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0; A = $urandom; B = $urandom;
    check("busy_on", 64'(Busy), 64'd1);
    check("done_low", 64'(Done), 64'd0);
    if (intrude) begin
      MDOp = 4'd9; A = 32'hDEADBEEF; Start = 1'b1;
    end
    n = 0;
    while (Done !== 1'b1 && n < 200) begin
      if (Busy === 1'b1) n++;
      @(negedge clk);
      Start = 1'b0; MDOp = 4'd0;
    end
    check("latency", 64'(n), 64'(lat));
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [31:0] a);
    {m_hi, m_lo} = model(op, a, 32'd0, {m_hi, m_lo});
    MDOp = op; A = a; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    check("mt_busy", 64'(Busy), 64'd0);
    check("mt_done", 64'(Done), 64'd0);
    check("mt_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  task automatic blocked_op(input logic irq_v, input logic eret_v);
    MDOp = 4'd1; A = 32'd5; B = 32'd6; Start = 1'b1; IRQ = irq_v; eret = eret_v;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; IRQ = 1'b0; eret = 1'b0; MDOp = 4'd0;
    check("blocked_busy", 64'(Busy), 64'd0);
    check("blocked_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, Lat, 1'b0);
    check("multu_max", {HI, LO}, 64'hFFFFFFFE_00000001);
    run_op(4'd1, 32'hFFFFFFF9, 32'd3, Lat, 1'b0);
    check("mult_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, DivLat, 1'b0);
    check("div_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd4, 32'd7, 32'd2, DivLat, 1'b0);
    check("divu", {HI, LO}, 64'h00000001_00000003);
    run_op(4'd4, 32'd5, 32'd0, DivLat, 1'b0);
    check("divu_zero", {HI, LO}, 64'h00000005_FFFFFFFF);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, DivLat, 1'b0);
    check("div_ovf", {HI, LO}, 64'h00000000_80000000);

    // mthi immediately after a commit, then MAC chain
    mt_op(4'd9, 32'd0);
    mt_op(4'd10, 32'hFFFFFFFF);
    run_op(4'd6, 32'd1, 32'd1, Lat, 1'b0);
    check("maddu", {HI, LO}, 64'h00000001_00000000);
    run_op(4'd8, 32'd1, 32'd1, Lat, 1'b0);
    check("msubu", {HI, LO}, 64'h00000000_FFFFFFFF);
    run_op(4'd7, 32'd1, 32'd1, Lat, 1'b0);
    check("msub", {HI, LO}, 64'h00000000_FFFFFFFE);

    blocked_op(1'b1, 1'b0);
    blocked_op(1'b0, 1'b1);

    run_op(4'd1, 32'd1234, 32'd10, Lat, 1'b1);
    check("intrude_hi", 64'(HI), 64'd0);

    for (int i = 0; i < 8; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(op, a, b, (op == 4'd3 || op == 4'd4) ? DivLat : Lat, 1'b0);
    end

    // Reset in the middle of a divide drops it without a commit
    MDOp = 4'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", 64'(Busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async_busy", 64'(Busy), 64'd0);
    check("async_done", 64'(Done), 64'd0);
    check("async_hilo", {HI, LO}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(4'd2, 32'd3, 32'd4, Lat, 1'b0);
    check("post_rst_multu", {HI, LO}, 64'h00000000_0000000C);

    @(negedge clk);
    check("done_pulse", 64'(Done), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
